// File: rtl/led16_serial_driver.sv
// Serial shift-out driver for a chain of LED shift registers. A captured pattern
// is clocked out one bit per two ticks, then the outputs are re-enabled.
module led16_serial_driver #(
    parameter int WIDTH     = 16,
    parameter bit MSB_FIRST = 1'b1,
    parameter bit INVERT    = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick,
    input  logic             start,
    input  logic [WIDTH-1:0] data,
    output logic             busy,
    output logic             done,
    output logic             led_clk,
    output logic             led_do,
    output logic             led_pen,
    output logic             led_clr_n
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, SHIFT_L, SHIFT_H, LATCH} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             led_clk_q, led_clk_d;
    logic             led_do_q, led_do_d;
    logic             led_pen_q, led_pen_d;
    logic             led_clr_n_q, led_clr_n_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = SHIFT_L;
            SHIFT_L: if (tick)  state_d = SHIFT_H;
            SHIFT_H: if (tick)  state_d = (cnt_q == LAST) ? LATCH : SHIFT_L;
            LATCH:   if (tick)  state_d = IDLE;
            default:            state_d = IDLE;
        endcase
    end

    // Capture in IDLE ignores tick, so a tick coincident with start is not
    // spent on shifting and every frame costs exactly 2*WIDTH+1 ticks.
    always_comb begin
        sreg_d      = sreg_q;
        cnt_d       = cnt_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        led_clk_d   = led_clk_q;
        led_do_d    = led_do_q;
        led_pen_d   = led_pen_q;
        led_clr_n_d = 1'b1;
        case (state_q)
            IDLE: begin
                if (start) begin
                    sreg_d    = INVERT ? ~data : data;
                    cnt_d     = '0;
                    busy_d    = 1'b1;
                    led_pen_d = 1'b0;
                end
            end
            SHIFT_L: begin
                if (tick) begin
                    led_clk_d = 1'b0;
                    led_do_d  = MSB_FIRST ? sreg_q[WIDTH-1] : sreg_q[0];
                end
            end
            SHIFT_H: begin
                if (tick) begin
                    led_clk_d = 1'b1;
                    sreg_d    = MSB_FIRST ? (sreg_q << 1) : (sreg_q >> 1);
                    if (cnt_q != LAST) cnt_d = cnt_q + CW'(1);
                end
            end
            LATCH: begin
                if (tick) begin
                    led_clk_d = 1'b0;
                    led_pen_d = 1'b1;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sreg_q      <= '0;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            led_clk_q   <= 1'b0;
            led_do_q    <= 1'b0;
            led_pen_q   <= 1'b0;
            led_clr_n_q <= 1'b0;
        end else begin
            sreg_q      <= sreg_d;
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            led_clk_q   <= led_clk_d;
            led_do_q    <= led_do_d;
            led_pen_q   <= led_pen_d;
            led_clr_n_q <= led_clr_n_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign led_clk   = led_clk_q;
    assign led_do    = led_do_q;
    assign led_pen   = led_pen_q;
    assign led_clr_n = led_clr_n_q;

endmodule

// File: tb/tb_led16_serial_driver.sv
// Directed bench for led16_serial_driver: three parameter variants share stimulus
// and the serial stream of each is reassembled on led_clk rises.
module tb_led16_serial_driver;

    localparam int BUDGET = 400;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        tick, start;
    logic [15:0] data;

    logic busy0, done0, lclk0, ldo0, pen0, clrn0;
    logic busy1, done1, lclk1, ldo1, pen1, clrn1;
    logic busy2, done2, lclk2, ldo2, pen2, clrn2;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    led16_serial_driver dut (
        .clk(clk), .rst_n(rst_n), .tick(tick), .start(start), .data(data),
        .busy(busy0), .done(done0), .led_clk(lclk0), .led_do(ldo0),
        .led_pen(pen0), .led_clr_n(clrn0)
    );

    led16_serial_driver #(.MSB_FIRST(1'b1), .INVERT(1'b0)) dut_n (
        .clk(clk), .rst_n(rst_n), .tick(tick), .start(start), .data(data),
        .busy(busy1), .done(done1), .led_clk(lclk1), .led_do(ldo1),
        .led_pen(pen1), .led_clr_n(clrn1)
    );

    led16_serial_driver #(.MSB_FIRST(1'b0), .INVERT(1'b0)) dut_l (
        .clk(clk), .rst_n(rst_n), .tick(tick), .start(start), .data(data),
        .busy(busy2), .done(done2), .led_clk(lclk2), .led_do(ldo2),
        .led_pen(pen2), .led_clr_n(clrn2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Runs one frame from an accepted start. Bits are collected in arrival order,
    // so the first bit shifted ends up in [15]. c counts clk edges after accept.
    task automatic run_frame(input logic [15:0] d, input int period, input int mid_c,
                             input int stall_c, input int post,
                             output logic [15:0] g0, output logic [15:0] g1,
                             output logic [15:0] g2, output int rises,
                             output int done_cyc, output int done_hi,
                             output int busy_n, output int bad);
        logic pc, sdo;
        g0 = '0; g1 = '0; g2 = '0;
        rises = 0; done_cyc = -1; done_hi = 0; busy_n = 0; bad = 0;
        pc = 1'b0; sdo = 1'b0;
        start = 1'b1; data = d; tick = (period == 1);
        for (int c = 0; c < BUDGET; c++) begin
            if (c > 0) begin
                if (c == stall_c) begin
                    start = 1'b0; tick = 1'b0;
                    for (int s = 0; s < 50; s++) begin
                        @(negedge clk);
                        if (lclk0 !== pc || ldo0 !== sdo || busy0 !== 1'b1) bad++;
                    end
                end
                start = (c == mid_c);
                if (c == mid_c) data = 16'hFFFF;
                tick = (c % period == 0);
            end
            @(negedge clk);
            if (busy0) busy_n++;
            if (busy0 && pen0) bad++;
            if (done0) begin
                done_hi++;
                if (done_cyc < 0) done_cyc = c;
            end
            if (!pc && lclk0) begin
                rises++;
                g0 = {g0[14:0], ldo0};
                g1 = {g1[14:0], ldo1};
                g2 = {g2[14:0], ldo2};
            end
            pc = lclk0; sdo = ldo0;
            if (done_cyc >= 0 && c >= done_cyc + post) break;
        end
        start = 1'b0;
    endtask

    logic [15:0] g0, g1, g2;
    int rises, dcyc, dhi, bn, bad;

    initial begin
        rst_n = 1'b0; tick = 1'b0; start = 1'b0; data = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy0, 0);
        check("rst_done", done0, 0);
        check("rst_lclk", lclk0, 0);
        check("rst_ldo", ldo0, 0);
        check("rst_pen", pen0, 0);
        check("rst_clrn", clrn0, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("clrn_release", clrn0, 1);
        check("idle_busy", busy0, 0);

        // T1: tick every clk, inverted MSB-first
        run_frame(16'hA5C3, 1, -1, -1, 2, g0, g1, g2, rises, dcyc, dhi, bn, bad);
        check("t1_inv_msb", g0, 16'h5A3C);
        check("t1_msb", g1, 16'hA5C3);
        check("t1_lsb", g2, 16'hC3A5);
        check("t1_rises", rises, 16);
        check("t1_done_cyc", dcyc, 33);
        check("t1_done_w", dhi, 1);
        check("t1_busy_n", bn, 33);
        check("t1_bad", bad, 0);
        check("t1_pen_end", pen0, 1);
        check("t1_busy_end", busy0, 0);

        // T2: tick every 4th clk
        run_frame(16'h0001, 4, -1, -1, 3, g0, g1, g2, rises, dcyc, dhi, bn, bad);
        check("t2_inv_msb", g0, 16'hFFFE);
        check("t2_msb", g1, 16'h0001);
        check("t2_lsb", g2, 16'h8000);
        check("t2_rises", rises, 16);
        check("t2_done_cyc", dcyc, 132);
        check("t2_done_w", dhi, 1);
        check("t2_busy_n", bn, 132);
        check("t2_bad", bad, 0);
        check("t2_pen_end", pen0, 1);

        // T3: mid-frame start ignored; next start lands in the done cycle
        run_frame(16'h1234, 1, 10, -1, 0, g0, g1, g2, rises, dcyc, dhi, bn, bad);
        check("t3_inv_msb", g0, 16'hEDCB);
        check("t3_msb", g1, 16'h1234);
        check("t3_lsb", g2, 16'h2C48);
        check("t3_done_cyc", dcyc, 33);
        run_frame(16'hFFFF, 2, -1, -1, 2, g0, g1, g2, rises, dcyc, dhi, bn, bad);
        check("t3b_inv_msb", g0, 16'h0000);
        check("t3b_msb", g1, 16'hFFFF);
        check("t3b_lsb", g2, 16'hFFFF);
        check("t3b_done_cyc", dcyc, 66);
        check("t3b_busy_n", bn, 66);
        check("t3b_done_w", dhi, 1);

        // T4: reset after the 7th led_clk rise
        begin
            logic pc;
            int   r;
            pc = 1'b0; r = 0;
            start = 1'b1; data = 16'hA5C3; tick = 1'b1;
            @(negedge clk);
            start = 1'b0;
            for (int c = 0; c < 100 && r < 7; c++) begin
                @(negedge clk);
                if (!pc && lclk0) r++;
                pc = lclk0;
            end
            check("t4_rises", r, 7);
            check("t4_lclk_pre", lclk0, 1);
            rst_n = 1'b0;
            #1;
            check("t4_lclk", lclk0, 0);
            check("t4_busy", busy0, 0);
            check("t4_pen", pen0, 0);
            check("t4_clrn", clrn0, 0);
            check("t4_ldo", ldo0, 0);
            @(negedge clk);
            rst_n = 1'b1;
            @(negedge clk);
            check("t4_clrn_rel", clrn0, 1);
            check("t4_idle", busy0, 0);
        end
        run_frame(16'h0F0F, 1, -1, -1, 1, g0, g1, g2, rises, dcyc, dhi, bn, bad);
        check("t4b_inv_msb", g0, 16'hF0F0);
        check("t4b_msb", g1, 16'h0F0F);
        check("t4b_done_cyc", dcyc, 33);
        check("t4b_rises", rises, 16);

        // T5: LSB-first variant sees 15 zeros then a one
        run_frame(16'h8000, 1, -1, -1, 1, g0, g1, g2, rises, dcyc, dhi, bn, bad);
        check("t5_lsb", g2, 16'h0001);
        check("t5_msb", g1, 16'h8000);
        check("t5_inv_msb", g0, 16'h7FFF);

        // T6: 50 clk without tick while in SHIFT_H
        run_frame(16'h3C96, 1, -1, 6, 1, g0, g1, g2, rises, dcyc, dhi, bn, bad);
        check("t6_stall_bad", bad, 0);
        check("t6_msb", g1, 16'h3C96);
        check("t6_inv_msb", g0, 16'hC369);
        check("t6_done_cyc", dcyc, 33);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
